// File: rtl/fetch_cur_chroma_ctrl_if.sv
// Bus bundle between the chroma load sequencer, the external pixel read port
// and the load side of the chroma current-LCU buffer.
// master: sequencer side (drives requests and the buffer write stream).
// slave:  port/buffer side (acks requests, returns rows, consumes writes).
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

interface fetch_cur_chroma_ctrl_if #(
    parameter int LCU_W = 8
) ();
    localparam int ROW_W = 32 * `PIXEL_WIDTH;

    // external row read port
    logic               ext_rd_req_o;
    logic               ext_rd_ack_i;
    logic               ext_rd_sel_o;
    logic [LCU_W+4:0]   ext_rd_x_o;
    logic [LCU_W+4:0]   ext_rd_y_o;
    logic               ext_rd_valid_i;
    logic [ROW_W-1:0]   ext_rd_data_i;

    // load-side buffer write stream
    logic               ext_load_valid_o;
    logic [5:0]         ext_load_addr_o;
    logic [ROW_W-1:0]   ext_load_data_o;
    logic               ext_load_done_o;

    modport master (
        output ext_rd_req_o, ext_rd_sel_o, ext_rd_x_o, ext_rd_y_o,
        input  ext_rd_ack_i, ext_rd_valid_i, ext_rd_data_i,
        output ext_load_valid_o, ext_load_addr_o, ext_load_data_o, ext_load_done_o
    );

    modport slave (
        input  ext_rd_req_o, ext_rd_sel_o, ext_rd_x_o, ext_rd_y_o,
        output ext_rd_ack_i, ext_rd_valid_i, ext_rd_data_i,
        input  ext_load_valid_o, ext_load_addr_o, ext_load_data_o, ext_load_done_o
    );
endinterface

// File: rtl/fetch_cur_chroma_ctrl.sv
// Purpose: fetch the 32 U + 32 V chroma rows of one 64x64 LCU, one request per
//          row, and write the returned rows into the load-side buffer bank.
// Latency: start -> first request 1 cycle; accepted beat -> buffer write 1 cycle;
//          done pulses together with the 64th write.
// Backpressure: requests stall on ack low and when MAX_OUT rows are outstanding;
//          returned rows are never stalled (one beat per cycle accepted).
// Ports: clk/rstn; sysif_start_i + lcu x/y; bus (read port + write stream);
//        busy_o, sticky overrun_o and proto_err_o status.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module fetch_cur_chroma_ctrl #(
    parameter int LCU_W   = 8,
    parameter int MAX_OUT = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    sysif_start_i,
    input  logic [LCU_W-1:0]        sysif_lcu_x_i,
    input  logic [LCU_W-1:0]        sysif_lcu_y_i,
    fetch_cur_chroma_ctrl_if.master bus,
    output logic                    busy_o,
    output logic                    overrun_o,
    output logic                    proto_err_o
);
    localparam int          ROW_W     = 32 * `PIXEL_WIDTH;
    localparam logic [3:0]  MAX_OUT_C = 4'(MAX_OUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [LCU_W-1:0]   lcu_x;
    logic [LCU_W-1:0]   lcu_y;
    logic               pend_vld;
    logic [LCU_W-1:0]   pend_x;
    logic [LCU_W-1:0]   pend_y;
    logic [5:0]         req_cnt;   // next row to request: [5] plane, [4:0] row
    logic [6:0]         beat_cnt;  // rows written so far in this load
    logic [3:0]         out_cnt;   // acked requests whose row has not returned
    logic               load_valid;
    logic [5:0]         load_addr;
    logic [ROW_W-1:0]   load_data;

    logic hs;
    logic beat_acc;

    // Request is a function of registered state only, so fields stay stable
    // for as long as ack is held low.
    assign bus.ext_rd_req_o = (state == REQ) && (out_cnt < MAX_OUT_C);
    assign bus.ext_rd_sel_o = req_cnt[5];
    assign bus.ext_rd_x_o   = {lcu_x, 5'd0};
    // lcu_y*32 + row never carries, so concatenation is the sum
    assign bus.ext_rd_y_o   = {lcu_y, req_cnt[4:0]};

    assign hs       = bus.ext_rd_req_o && bus.ext_rd_ack_i;
    // A beat with nothing outstanding cannot belong to us; drop it.
    assign beat_acc = bus.ext_rd_valid_i && (out_cnt != 4'd0);

    assign bus.ext_load_valid_o = load_valid;
    assign bus.ext_load_addr_o  = load_addr;
    assign bus.ext_load_data_o  = load_data;
    assign bus.ext_load_done_o  = (state == DONE);
    assign busy_o               = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            lcu_x       <= '0;
            lcu_y       <= '0;
            pend_vld    <= 1'b0;
            pend_x      <= '0;
            pend_y      <= '0;
            req_cnt     <= '0;
            beat_cnt    <= '0;
            out_cnt     <= '0;
            load_valid  <= 1'b0;
            load_addr   <= '0;
            load_data   <= '0;
            overrun_o   <= 1'b0;
            proto_err_o <= 1'b0;
        end else begin
            // outstanding count: simultaneous ack and return cancel out
            case ({hs, beat_acc})
                2'b10:   out_cnt <= out_cnt + 4'd1;
                2'b01:   out_cnt <= out_cnt - 4'd1;
                default: out_cnt <= out_cnt;
            endcase

            if (bus.ext_rd_valid_i && (out_cnt == 4'd0)) begin
                proto_err_o <= 1'b1;
            end

            // registered write stream: address is the beat index at accept time
            load_valid <= beat_acc;
            if (beat_acc) begin
                load_addr <= beat_cnt[5:0];
                load_data <= bus.ext_rd_data_i;
                beat_cnt  <= beat_cnt + 7'd1;
            end

            case (state)
                IDLE: begin
                    if (sysif_start_i) begin
                        lcu_x    <= sysif_lcu_x_i;
                        lcu_y    <= sysif_lcu_y_i;
                        req_cnt  <= '0;
                        beat_cnt <= '0;
                        state    <= REQ;
                    end
                end

                REQ, WAIT: begin
                    if (sysif_start_i) begin
                        if (pend_vld) begin
                            overrun_o <= 1'b1;
                        end else begin
                            pend_vld <= 1'b1;
                            pend_x   <= sysif_lcu_x_i;
                            pend_y   <= sysif_lcu_y_i;
                        end
                    end
                    if (state == REQ) begin
                        if (hs) begin
                            req_cnt <= req_cnt + 6'd1;
                            if (req_cnt == 6'd63) begin
                                state <= WAIT;
                            end
                        end
                    end else if (beat_acc && (beat_cnt == 7'd63)) begin
                        // leave on the 64th accept so done lines up with the last write
                        state <= DONE;
                    end
                end

                DONE: begin
                    if (pend_vld) begin
                        lcu_x    <= pend_x;
                        lcu_y    <= pend_y;
                        pend_vld <= 1'b0;
                        req_cnt  <= '0;
                        beat_cnt <= '0;
                        state    <= REQ;
                        if (sysif_start_i) begin
                            overrun_o <= 1'b1;
                        end
                    end else if (sysif_start_i) begin
                        // a start landing in DONE is pending and consumed at once
                        lcu_x    <= sysif_lcu_x_i;
                        lcu_y    <= sysif_lcu_y_i;
                        req_cnt  <= '0;
                        beat_cnt <= '0;
                        state    <= REQ;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
